// File: rtl/nasti_rd_arbiter_if.sv
// NASTI read-path bundle: two requester AR/R ports plus one downstream port.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface nasti_rd_arbiter_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [1:0]              s_ar_valid;
    logic [1:0]              s_ar_ready;
    logic [2*ID_WIDTH-1:0]   s_ar_id;
    logic [2*ADDR_WIDTH-1:0] s_ar_addr;
    logic [15:0]             s_ar_len;
    logic [1:0]              s_r_valid;
    logic [1:0]              s_r_ready;
    logic [ID_WIDTH-1:0]     s_r_id;
    logic [DATA_WIDTH-1:0]   s_r_data;
    logic [1:0]              s_r_resp;
    logic                    s_r_last;
    logic                    m_ar_valid;
    logic                    m_ar_ready;
    logic [ID_WIDTH-1:0]     m_ar_id;
    logic [ADDR_WIDTH-1:0]   m_ar_addr;
    logic [7:0]              m_ar_len;
    logic                    m_r_valid;
    logic                    m_r_ready;
    logic [ID_WIDTH-1:0]     m_r_id;
    logic [DATA_WIDTH-1:0]   m_r_data;
    logic [1:0]              m_r_resp;
    logic                    m_r_last;

    modport slave (
        input  s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_r_ready,
        input  m_ar_ready, m_r_valid, m_r_id, m_r_data, m_r_resp, m_r_last,
        output s_ar_ready, s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
        output m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_r_ready
    );

    modport master (
        output s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_r_ready,
        output m_ar_ready, m_r_valid, m_r_id, m_r_data, m_r_resp, m_r_last,
        input  s_ar_ready, s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
        input  m_ar_valid, m_ar_id, m_ar_addr, m_ar_len, m_r_ready
    );
endinterface

// File: rtl/nasti_rd_arbiter.sv
// Two-requester round-robin NASTI read arbiter, one burst outstanding,
// with a sticky burst-length check on the downstream R stream.
module nasti_rd_arbiter #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rstn,
    nasti_rd_arbiter_if.slave bus,
    output logic [1:0] grant,
    output logic       len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_last_owner;
    logic [7:0]            r_cnt;
    logic                  r_len_err;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic                  w_sel;
    logic                  w_ar_hs;
    logic                  w_beat;

    // Both requesting: favour whoever did not own the previous burst.
    assign w_sel   = (&bus.s_ar_valid) ? ~r_last_owner : bus.s_ar_valid[1];
    assign w_ar_hs = (r_state == IDLE) && (|bus.s_ar_valid);
    assign w_beat  = (r_state == DATA) && bus.m_r_valid
                     && bus.s_r_ready[r_owner];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (|bus.s_ar_valid) w_next = ADDR;
            ADDR:    if (bus.m_ar_ready) w_next = DATA;
            DATA:    if (w_beat && bus.m_r_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ar_ready = 2'b00;
        bus.s_r_valid  = 2'b00;
        bus.m_ar_valid = 1'b0;
        bus.m_r_ready  = 1'b0;
        grant          = 2'b00;
        unique case (r_state)
            IDLE: begin
                bus.s_ar_ready[w_sel] = |bus.s_ar_valid;
            end
            ADDR: begin
                bus.m_ar_valid = 1'b1;
                grant[r_owner] = 1'b1;
            end
            DATA: begin
                bus.m_r_ready          = bus.s_r_ready[r_owner];
                bus.s_r_valid[r_owner] = bus.m_r_valid;
                grant[r_owner]         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= 8'd0;
            r_len_err    <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_owner <= w_sel;
                r_cnt   <= 8'd0;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 8'd1;
                if (bus.m_r_last) r_last_owner <= r_owner;
                // Early last, or a full count of beats without last.
                if (bus.m_r_last ? (r_cnt != r_len) : (r_cnt == r_len))
                    r_len_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ar_hs) begin
            r_id   <= w_sel ? bus.s_ar_id[ID_WIDTH +: ID_WIDTH]
                            : bus.s_ar_id[0 +: ID_WIDTH];
            r_addr <= w_sel ? bus.s_ar_addr[ADDR_WIDTH +: ADDR_WIDTH]
                            : bus.s_ar_addr[0 +: ADDR_WIDTH];
            r_len  <= w_sel ? bus.s_ar_len[15:8] : bus.s_ar_len[7:0];
        end
    end

    assign bus.m_ar_id   = r_id;
    assign bus.m_ar_addr = r_addr;
    assign bus.m_ar_len  = r_len;
    assign bus.s_r_id    = bus.m_r_id;
    assign bus.s_r_data  = bus.m_r_data;
    assign bus.s_r_resp  = bus.m_r_resp;
    assign bus.s_r_last  = bus.m_r_last;
    assign len_err       = r_len_err;
endmodule

// File: tb/tb_nasti_rd_arbiter.sv
// Randomized self-checking bench for nasti_rd_arbiter against a
// transaction-level round-robin / burst-length model.
module tb_nasti_rd_arbiter;
    localparam int IW = 1;
    localparam int AW = 8;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] grant;
    logic       len_err;

    int checks = 0;
    int errors = 0;
    int m_last = 1;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    nasti_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    nasti_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .grant   (grant),
        .len_err (len_err)
    );

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return 1 - m_last;
        return v[1] ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_ar_valid = 2'b00;
        bus.s_ar_id    = '0;
        bus.s_ar_addr  = '0;
        bus.s_ar_len   = '0;
        bus.s_r_ready  = 2'b00;
        bus.m_ar_ready = 1'b0;
        bus.m_r_valid  = 1'b0;
        bus.m_r_id     = '0;
        bus.m_r_data   = '0;
        bus.m_r_resp   = '0;
        bus.m_r_last   = 1'b0;
    endtask

    task automatic burst(input logic [1:0] req, input logic [AW-1:0] addr,
                         input int len, input int nbeats,
                         input int ar_stall, input int r_stall_at);
        int          sel;
        logic [1:0]  oh;
        logic [IW-1:0] id;
        logic [7:0]  l8;
        logic [DW-1:0] d;
        logic [1:0]  rsp;
        logic        last;
        sel = pick(req);
        oh  = 2'b01 << sel;
        id  = IW'($urandom);
        l8  = len[7:0];
        bus.s_ar_valid = req;
        bus.s_ar_id    = (2*IW)'($urandom);
        bus.s_ar_addr  = (2*AW)'($urandom);
        bus.s_ar_len   = 16'($urandom);
        bus.s_ar_id[sel*IW +: IW]   = id;
        bus.s_ar_addr[sel*AW +: AW] = addr;
        bus.s_ar_len[sel*8 +: 8]    = l8;
        #3;
        checks++;
        if (bus.s_ar_ready !== oh) begin
            errors++;
            $display("FAIL ar_ready: got %b expected %b", bus.s_ar_ready, oh);
        end
        checks++;
        if (grant !== 2'b00 || bus.m_ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_out: grant %b m_ar_valid %b expected 00/0",
                     grant, bus.m_ar_valid);
        end
        step();
        for (int i = 0; i <= ar_stall; i++) begin
            bus.m_ar_ready = (i == ar_stall);
            #3;
            checks++;
            if ({bus.m_ar_valid, bus.m_ar_id, bus.m_ar_addr, bus.m_ar_len}
                !== {1'b1, id, addr, l8}) begin
                errors++;
                $display("FAIL m_ar: got %b/%h/%h/%h expected 1/%h/%h/%h",
                         bus.m_ar_valid, bus.m_ar_id, bus.m_ar_addr,
                         bus.m_ar_len, id, addr, l8);
            end
            checks++;
            if (bus.s_ar_ready !== 2'b00 || grant !== oh) begin
                errors++;
                $display("FAIL addr_phase: ready %b grant %b expected 00/%b",
                         bus.s_ar_ready, grant, oh);
            end
            step();
        end
        bus.m_ar_ready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            d    = DW'($urandom);
            rsp  = 2'($urandom);
            last = (b == nbeats - 1);
            bus.m_r_valid = 1'b1;
            bus.m_r_data  = d;
            bus.m_r_resp  = rsp;
            bus.m_r_last  = last;
            bus.m_r_id    = IW'($urandom);
            if (b == r_stall_at) begin
                for (int k = 0; k < 3; k++) begin
                    bus.s_r_ready = ~oh;
                    #3;
                    checks++;
                    if (bus.m_r_ready !== 1'b0 || bus.s_r_valid !== oh) begin
                        errors++;
                        $display("FAIL r_stall: m_r_ready %b s_r_valid %b expected 0/%b",
                                 bus.m_r_ready, bus.s_r_valid, oh);
                    end
                    step();
                end
            end
            bus.s_r_ready = oh | (2'($urandom) & ~oh);
            #3;
            checks++;
            if ({bus.m_r_ready, bus.s_r_valid, bus.s_r_data, bus.s_r_resp,
                 bus.s_r_last, bus.s_r_id}
                !== {1'b1, oh, d, rsp, last, bus.m_r_id}) begin
                errors++;
                $display("FAIL r_beat%0d: rdy %b vld %b data %h resp %h last %b expected 1/%b/%h/%h/%b",
                         b, bus.m_r_ready, bus.s_r_valid, bus.s_r_data,
                         bus.s_r_resp, bus.s_r_last, oh, d, rsp, last);
            end
            checks++;
            if (grant !== oh) begin
                errors++;
                $display("FAIL data_grant: got %b expected %b", grant, oh);
            end
            if (last ? ((b % 256) != len) : ((b % 256) == len)) m_err = 1'b1;
            step();
            checks++;
            if (len_err !== m_err) begin
                errors++;
                $display("FAIL len_err beat%0d: got %b expected %b", b, len_err, m_err);
            end
        end
        idle_inputs();
        m_last = sel;
        #1;
        checks++;
        if (grant !== 2'b00 || bus.s_r_valid !== 2'b00) begin
            errors++;
            $display("FAIL post_burst: grant %b s_r_valid %b expected 00/00",
                     grant, bus.s_r_valid);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        m_last = 1;
        m_err  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #3;
        checks++;
        if ({grant, bus.m_ar_valid, bus.m_r_ready, bus.s_r_valid, len_err,
             bus.s_ar_ready} !== 9'b0) begin
            errors++;
            $display("FAIL reset: grant %b arv %b rrdy %b rv %b err %b ardy %b expected all 0",
                     grant, bus.m_ar_valid, bus.m_r_ready, bus.s_r_valid,
                     len_err, bus.s_ar_ready);
        end
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        burst(2'b01, 8'h10, 3, 4, 0, -1);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) burst(2'b11, AW'($urandom), 0, 1, 0, -1);
    endtask

    task automatic test_ar_stall();
        burst(2'b01, AW'($urandom), 2, 3, 5, -1);
    endtask

    task automatic test_r_stall();
        burst(2'b10, AW'($urandom), 4, 5, 0, 2);
    endtask

    task automatic test_random();
        int len;
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(0, 6);
            burst(2'($urandom_range(1, 3)), AW'($urandom), len, len + 1,
                  $urandom_range(0, 2), $urandom_range(0, len + 2));
        end
    endtask

    task automatic test_len255();
        burst(2'b11, AW'($urandom), 255, 256, 0, -1);
        burst(2'b01, AW'($urandom), 1, 2, 0, -1);
    endtask

    task automatic test_len_err();
        burst(2'b01, AW'($urandom), 1, 1, 0, -1);
        burst(2'b10, AW'($urandom), 2, 3, 0, -1);
        burst(2'b11, AW'($urandom), 0, 1, 0, -1);
        do_reset();
        burst(2'b01, AW'($urandom), 1, 3, 0, -1);
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        bus.s_ar_valid = 2'b01;
        bus.s_ar_len   = 16'h0003;
        step();
        bus.s_ar_valid = 2'b00;
        bus.m_ar_ready = 1'b1;
        step();
        bus.m_ar_ready = 1'b0;
        bus.m_r_valid  = 1'b1;
        bus.s_r_ready  = 2'b01;
        step();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || bus.s_r_valid !== 2'b00
            || bus.m_r_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: grant %b s_r_valid %b m_r_ready %b expected 00/00/0",
                     grant, bus.s_r_valid, bus.m_r_ready);
        end
        idle_inputs();
        step();
        rstn = 1'b1;
        m_last = 1;
        m_err  = 1'b0;
        step();
        burst(2'b10, AW'($urandom), 1, 2, 0, -1);
        burst(2'b11, AW'($urandom), 0, 1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_ar_stall();
        test_r_stall();
        test_random();
        test_len255();
        test_len_err();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
